// File: rtl/i2s_pkg.sv
// Shared constants and helpers for the microphone-array I2S receiver.
//   BCLK_DIV_DEFAULT / SLOT_BITS_DEFAULT / DATA_BITS_DEFAULT : default timing
//   clip_limits() : max-positive / max-negative codes for a given sample width
package i2s_pkg;

    localparam int BCLK_DIV_DEFAULT  = 16;
    localparam int SLOT_BITS_DEFAULT = 32;
    localparam int DATA_BITS_DEFAULT = 18;

    typedef struct packed {
        logic [31:0] max_pos;
        logic [31:0] max_neg;
    } clip_limits_t;

    // Limits are returned zero-extended to 32 bits; callers keep the low
    // `width` bits (0111..1 and 1000..0 in two's complement).
    function automatic clip_limits_t clip_limits(input int width);
        clip_limits_t lim;
        lim.max_pos = (32'd1 << (width - 1)) - 32'd1;
        lim.max_neg = 32'd1 << (width - 1);
        return lim;
    endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// Shared BCLK / LRCL generator for all capture lanes.
//   clk_in   : audio clock
//   rst_in   : asynchronous active-high reset
//   bclk_out : bit clock, toggles every BCLK_DIV clk_in cycles
//   lrcl_out : word select, high while bit_cnt >= SLOT_BITS
//   rise_stb : high in the clk_in cycle whose edge drives bclk_out 0->1
//   bit_cnt  : bit position in the frame, advances on BCLK falling edges
module i2s_clk_gen
    import i2s_pkg::*;
#(
    parameter int BCLK_DIV  = BCLK_DIV_DEFAULT,
    parameter int SLOT_BITS = SLOT_BITS_DEFAULT,
    localparam int DIV_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1,
    localparam int BIT_W    = $clog2(2 * SLOT_BITS)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    output logic             bclk_out,
    output logic             lrcl_out,
    output logic             rise_stb,
    output logic [BIT_W-1:0] bit_cnt
);

    logic [DIV_W-1:0] div_cnt;
    logic             div_wrap;
    logic             fall_stb;
    logic [BIT_W-1:0] bit_cnt_next;

    assign div_wrap = (div_cnt == DIV_W'(BCLK_DIV - 1));
    assign rise_stb = div_wrap && !bclk_out;
    assign fall_stb = div_wrap && bclk_out;

    always_comb begin
        bit_cnt_next = bit_cnt + 1'b1;
        if (bit_cnt == BIT_W'(2 * SLOT_BITS - 1)) begin
            bit_cnt_next = '0;
        end
    end

    // lrcl_out is computed from the post-increment count so it moves on the
    // same clk_in edge as the BCLK falling edge.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            div_cnt  <= '0;
            bclk_out <= 1'b0;
            bit_cnt  <= '0;
            lrcl_out <= 1'b0;
        end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
            if (div_wrap) begin
                bclk_out <= !bclk_out;
            end
            if (fall_stb) begin
                bit_cnt  <= bit_cnt_next;
                lrcl_out <= (bit_cnt_next >= BIT_W'(SLOT_BITS));
            end
        end
    end

endmodule

// File: rtl/i2s_mic_array_rx.sv
// Multi-lane I2S receiver: one shared clock generator, NUM_MICS frame-aligned
// capture lanes from left-slot (SEL grounded) microphones.
//   clk_in, rst_in   : audio clock, asynchronous active-high reset
//   mic_data_in      : serial data, one bit per mic
//   mic_en_in        : lane enable mask, latched at the start of each frame
//   clip_clr_in      : clears all sticky clip flags (a same-cycle set wins)
//   bclk_out, lrcl_out : I2S bit clock and word select
//   audio_out        : lane i at [i*SAMPLE_WIDTH +: SAMPLE_WIDTH], signed
//   data_valid_out   : one-cycle strobe, all lanes updated together
//   clip_out         : sticky per-lane clip flags
//   frame_cnt_out    : completed frames, wraps
module i2s_mic_array_rx
    import i2s_pkg::*;
#(
    parameter int NUM_MICS     = 3,
    parameter int BCLK_DIV     = BCLK_DIV_DEFAULT,
    parameter int SLOT_BITS    = SLOT_BITS_DEFAULT,
    parameter int DATA_BITS    = DATA_BITS_DEFAULT,
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic [NUM_MICS-1:0]              mic_data_in,
    input  logic [NUM_MICS-1:0]              mic_en_in,
    input  logic                             clip_clr_in,
    output logic                             bclk_out,
    output logic                             lrcl_out,
    output logic [NUM_MICS*SAMPLE_WIDTH-1:0] audio_out,
    output logic                             data_valid_out,
    output logic [NUM_MICS-1:0]              clip_out,
    output logic [15:0]                      frame_cnt_out
);

    localparam int BIT_W = $clog2(2 * SLOT_BITS);
    localparam clip_limits_t LIMITS = clip_limits(SAMPLE_WIDTH);
    localparam logic signed [SAMPLE_WIDTH-1:0] MAX_POS = LIMITS.max_pos[SAMPLE_WIDTH-1:0];
    localparam logic signed [SAMPLE_WIDTH-1:0] MAX_NEG = LIMITS.max_neg[SAMPLE_WIDTH-1:0];

    function automatic logic is_clip(input logic signed [SAMPLE_WIDTH-1:0] s);
        return (s == MAX_POS) || (s == MAX_NEG);
    endfunction

    logic             rise_stb;
    logic [BIT_W-1:0] bit_cnt;
    logic             capture;
    logic             vld_p0;
    logic [NUM_MICS-1:0] en_latched;
    logic [NUM_MICS-1:0] clip_hit;

    i2s_clk_gen #(
        .BCLK_DIV  (BCLK_DIV),
        .SLOT_BITS (SLOT_BITS)
    ) u_clk_gen (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .bclk_out (bclk_out),
        .lrcl_out (lrcl_out),
        .rise_stb (rise_stb),
        .bit_cnt  (bit_cnt)
    );

    // Bit 0 is the I2S one-bit delay; right-slot bits are never captured.
    assign capture = rise_stb && (bit_cnt >= BIT_W'(1)) && (bit_cnt <= BIT_W'(DATA_BITS));

    for (genvar i = 0; i < NUM_MICS; i++) begin : g_lane
        logic [DATA_BITS-1:0]           shift;
        logic signed [SAMPLE_WIDTH-1:0] sample;
        logic signed [SAMPLE_WIDTH-1:0] sample_p1;

        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                shift <= '0;
            end else if (capture) begin
                shift <= {shift[DATA_BITS-2:0], mic_data_in[i]};
            end
        end

        // Truncate to the top SAMPLE_WIDTH bits; disabled lanes read as silence.
        assign sample      = en_latched[i] ? shift[DATA_BITS-1 -: SAMPLE_WIDTH] : '0;
        assign clip_hit[i] = en_latched[i] && is_clip(sample);

        // ---- stage p1: lane sample register ----
        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                sample_p1 <= '0;
            end else if (vld_p0) begin
                sample_p1 <= sample;
            end
        end

        assign audio_out[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] = sample_p1;
    end

    // ---- stage p0: last data bit captured, all lane shifts complete ----
    // ---- stage p1: outputs, valid strobe, frame count, clip flags ----
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            vld_p0         <= 1'b0;
            data_valid_out <= 1'b0;
            en_latched     <= '0;
            frame_cnt_out  <= '0;
            clip_out       <= '0;
        end else begin
            vld_p0         <= rise_stb && (bit_cnt == BIT_W'(DATA_BITS));
            data_valid_out <= vld_p0;
            // Latching at the delay bit keeps the mask constant for a whole frame.
            if (rise_stb && (bit_cnt == '0)) begin
                en_latched <= mic_en_in;
            end
            if (vld_p0) begin
                frame_cnt_out <= frame_cnt_out + 1'b1;
            end
            clip_out <= (clip_clr_in ? '0 : clip_out) | (vld_p0 ? clip_hit : '0);
        end
    end

endmodule

// File: tb/tb_i2s_mic_array_rx.sv
module tb_i2s_mic_array_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic bit_val(input logic [17:0] w, input int b);
        if (b >= 1 && b <= 18) return w[18-b];
        return 1'b1;
    endfunction

    // ---------------- DUT A: defaults ----------------
    logic        rst;
    logic [2:0]  mic_data;
    logic [2:0]  mic_en;
    logic        clip_clr;
    logic        bclk_a, lrcl_a, dv_a;
    logic [47:0] audio_a;
    logic [2:0]  clip_a;
    logic [15:0] fc_a;

    i2s_mic_array_rx #(.NUM_MICS(3)) dut_a (
        .clk_in(clk), .rst_in(rst), .mic_data_in(mic_data), .mic_en_in(mic_en),
        .clip_clr_in(clip_clr), .bclk_out(bclk_a), .lrcl_out(lrcl_a),
        .audio_out(audio_a), .data_valid_out(dv_a), .clip_out(clip_a),
        .frame_cnt_out(fc_a)
    );

    // ---------------- DUT B: 4 lanes, BCLK_DIV 8, 18-bit samples ----------------
    logic        rst_b;
    logic [3:0]  mic_data_b;
    logic [3:0]  mic_en_b;
    logic        clip_clr_b;
    logic        bclk_b, lrcl_b, dv_b;
    logic [71:0] audio_b;
    logic [3:0]  clip_b;
    logic [15:0] fc_b;

    i2s_mic_array_rx #(.NUM_MICS(4), .BCLK_DIV(8), .SAMPLE_WIDTH(18)) dut_b (
        .clk_in(clk), .rst_in(rst_b), .mic_data_in(mic_data_b), .mic_en_in(mic_en_b),
        .clip_clr_in(clip_clr_b), .bclk_out(bclk_b), .lrcl_out(lrcl_b),
        .audio_out(audio_b), .data_valid_out(dv_b), .clip_out(clip_b),
        .frame_cnt_out(fc_b)
    );

    // Cycle counters: cycle 1 is the first rising edge after reset release.
    int cyc = 0, cyc_b = 0;
    always @(posedge clk) begin
        cyc   = rst   ? 0 : cyc + 1;
        cyc_b = rst_b ? 0 : cyc_b + 1;
    end

    // Mic BFMs: advance bit index on each BCLK falling edge, drive MSB first.
    logic [17:0] word_a [3];
    int   bit_a = 0, bit_b = 0;
    logic bprev_a = 1'b0, bprev_b = 1'b0;

    always @(negedge clk) begin
        if (rst) bit_a = 0;
        else if (bprev_a && !bclk_a) bit_a = (bit_a + 1) % 64;
        bprev_a = bclk_a;
        for (int i = 0; i < 3; i++) mic_data[i] = bit_val(word_a[i], bit_a);
    end

    always @(negedge clk) begin
        if (rst_b) bit_b = 0;
        else if (bprev_b && !bclk_b) bit_b = (bit_b + 1) % 64;
        bprev_b = bclk_b;
        for (int i = 0; i < 4; i++) mic_data_b[i] = bit_val(18'(i + 1), bit_b);
    end

    // Scoreboard for DUT A.
    typedef struct {
        logic [47:0] audio;
        logic [2:0]  clip;
        logic [15:0] fc;
    } exp_t;
    exp_t sb[$];

    task automatic push_exp(input logic [15:0] l2, input logic [15:0] l1, input logic [15:0] l0,
                            input logic [2:0] clip, input logic [15:0] fc);
        exp_t e;
        e.audio = {l2, l1, l0};
        e.clip  = clip;
        e.fc    = fc;
        sb.push_back(e);
    endtask

    // Monitor A: strobe timing, scoreboard compare, clock waveform checks.
    int vld_a = 0;
    int last_vld = 0, last_rise = -1, last_lr_rise = -1;
    logic mb_prev = 1'b0, ml_prev = 1'b0;
    logic [47:0] last_audio = '0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last_vld = 0; last_rise = -1; last_lr_rise = -1;
            mb_prev = bclk_a; ml_prev = lrcl_a; last_audio = '0;
        end else begin
            if (dv_a) begin
                vld_a++;
                if (last_vld == 0) chk("first_valid_cycle", cyc, 593);
                else               chk("valid_period", cyc - last_vld, 2048);
                last_vld = cyc;
                chk("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("audio", audio_a, e.audio);
                    chk("frame_cnt", fc_a, e.fc);
                    chk("clip", clip_a, e.clip);
                end
                last_audio = audio_a;
            end
            if (bclk_a && !mb_prev) begin
                if (last_rise >= 0) chk("bclk_period", cyc - last_rise, 32);
                last_rise = cyc;
                chk("audio_hold", audio_a, last_audio);
            end
            if (!bclk_a && mb_prev) chk("bclk_high", cyc - last_rise, 16);
            if (lrcl_a != ml_prev) begin
                chk("lrcl_on_bclk_fall", {mb_prev, bclk_a}, 2'b10);
                if (lrcl_a) begin
                    if (last_lr_rise >= 0) chk("lrcl_period", cyc - last_lr_rise, 2048);
                    last_lr_rise = cyc;
                end else begin
                    chk("lrcl_high", cyc - last_lr_rise, 1024);
                end
            end
            mb_prev = bclk_a;
            ml_prev = lrcl_a;
        end
    end

    // Monitor B: fixed lane pattern, 18-bit samples, 1024-cycle period.
    int last_vld_b = 0, fc_exp_b = 0;
    always @(negedge clk) begin
        if (!rst_b && dv_b) begin
            fc_exp_b++;
            if (last_vld_b == 0) chk("b_first_valid_cycle", cyc_b, 297);
            else                 chk("b_valid_period", cyc_b - last_vld_b, 1024);
            last_vld_b = cyc_b;
            chk("b_audio", audio_b, {18'h00004, 18'h00003, 18'h00002, 18'h00001});
            chk("b_frame_cnt", fc_b, 16'(fc_exp_b));
            chk("b_clip", clip_b, 4'b0000);
        end
    end

    task automatic wait_strobes(input int n);
        int target;
        int budget;
        target = vld_a + n;
        budget = n * 2048 + 1200;
        while (vld_a < target && budget > 0) begin
            @(negedge clk); #1;
            budget--;
        end
        chk("strobe_timeout", vld_a >= target, 1);
    endtask

    task automatic wait_bit(input int b);
        int budget;
        budget = 2200;
        while (bit_a != b && budget > 0) begin
            @(negedge clk); #1;
            budget--;
        end
        chk("bit_wait_timeout", bit_a == b, 1);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_bclk", bclk_a, 1'b0);
        chk("rst_lrcl", lrcl_a, 1'b0);
        chk("rst_audio", audio_a, 48'h0);
        chk("rst_valid", dv_a, 1'b0);
        chk("rst_clip", clip_a, 3'b000);
        chk("rst_frame_cnt", fc_a, 16'h0);
    endtask

    initial begin
        rst = 1'b1; rst_b = 1'b1;
        clip_clr = 1'b0; clip_clr_b = 1'b0;
        mic_en = 3'b111; mic_en_b = 4'hF;
        word_a[0] = 18'h2AAAA; word_a[1] = 18'h15555; word_a[2] = 18'h00004;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs();
        rst = 1'b0; rst_b = 1'b0;

        // Basic capture: three frames.
        push_exp(16'h0001, 16'h5555, 16'hAAAA, 3'b000, 16'd1);
        push_exp(16'h0001, 16'h5555, 16'hAAAA, 3'b000, 16'd2);
        push_exp(16'h0001, 16'h5555, 16'hAAAA, 3'b000, 16'd3);
        wait_strobes(3);

        // Clipping: lane 1 max-positive, lane 2 max-negative.
        word_a[1] = 18'h1FFFF; word_a[2] = 18'h20000;
        push_exp(16'h8000, 16'h7FFF, 16'hAAAA, 3'b110, 16'd4);
        push_exp(16'h8000, 16'h7FFF, 16'hAAAA, 3'b110, 16'd5);
        wait_strobes(2);

        clip_clr = 1'b1;
        @(negedge clk); #1;
        clip_clr = 1'b0;
        chk("clip_clr_mid", clip_a, 3'b000);
        push_exp(16'h8000, 16'h7FFF, 16'hAAAA, 3'b110, 16'd6);
        wait_strobes(1);

        // Clear held across the strobe: the set must win.
        clip_clr = 1'b1;
        @(negedge clk); #1;
        chk("clip_clr_held", clip_a, 3'b000);
        push_exp(16'h8000, 16'h7FFF, 16'hAAAA, 3'b110, 16'd7);
        wait_strobes(1);
        clip_clr = 1'b0;
        push_exp(16'h8000, 16'h7FFF, 16'hAAAA, 3'b110, 16'd8);
        wait_strobes(1);

        // Stop clipping: flags stay set until cleared.
        word_a[1] = 18'h15555; word_a[2] = 18'h00004;
        push_exp(16'h0001, 16'h5555, 16'hAAAA, 3'b110, 16'd9);
        wait_strobes(1);
        clip_clr = 1'b1;
        @(negedge clk); #1;
        clip_clr = 1'b0;
        chk("clip_cleared", clip_a, 3'b000);
        push_exp(16'h0001, 16'h5555, 16'hAAAA, 3'b000, 16'd10);
        wait_strobes(1);

        // Enable mask change mid-frame takes effect in the following frame.
        push_exp(16'h0001, 16'h5555, 16'hAAAA, 3'b000, 16'd11);
        push_exp(16'h0001, 16'h0000, 16'hAAAA, 3'b000, 16'd12);
        wait_bit(10);
        mic_en = 3'b101;
        wait_strobes(2);

        // Mid-frame reset: immediate zero outputs, aborted frame never strobes.
        wait_bit(12);
        rst = 1'b1;
        #1;
        chk_reset_outputs();
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs();
        rst = 1'b0;
        push_exp(16'h0001, 16'h0000, 16'hAAAA, 3'b000, 16'd1);
        wait_strobes(1);

        chk("sb_drained", sb.size(), 0);
        chk("b_strobes_seen", fc_exp_b > 20, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2s_mic_array_rx.md
Name: i2s_mic_array_rx

Overview:
- Parametrised multi-channel I2S receiver for the microphone array. It replaces the per-mic single-channel receivers with one shared BCLK/LRCL generator and NUM_MICS synchronous capture lanes.
- All lanes are sampled on the same bit edges. Their samples are presented together with a single valid strobe, so downstream filters, the speed-of-sound calculator and the delay line see frame-aligned data.
- New relative to the single-channel receiver: per-lane enable mask, sticky per-lane clip flags, and a frame counter.

Parameters:
- NUM_MICS, 3, number of capture lanes (1..8).
- BCLK_DIV, 16, clk_in cycles per BCLK half-period. 98.304 MHz / 32 = 3.072 MHz BCLK.
- SLOT_BITS, 32, BCLK periods per LR half-frame. Frame = 2*SLOT_BITS BCLKs, giving 48 kHz at the defaults.
- DATA_BITS, 18, valid MSB-first bits the mic drives per slot. Must satisfy DATA_BITS < SLOT_BITS.
- SAMPLE_WIDTH, 16, output sample width. Must satisfy SAMPLE_WIDTH <= DATA_BITS.

Ports:
- clk_in  input  1  audio clock (98.304 MHz)
- rst_in  input  1  asynchronous, active-high reset
- mic_data_in  input  NUM_MICS  serial data, one bit per mic
- mic_en_in  input  NUM_MICS  lane enable mask
- clip_clr_in  input  1  clears all clip flags
- bclk_out  output  1  I2S bit clock, fanned out to all mics by the top level
- lrcl_out  output  1  I2S word select
- audio_out  output  NUM_MICS*SAMPLE_WIDTH  signed samples; lane i occupies [i*SAMPLE_WIDTH +: SAMPLE_WIDTH]
- data_valid_out  output  1  one-cycle strobe; all lanes updated together
- clip_out  output  NUM_MICS  sticky clip flags
- frame_cnt_out  output  16  frames completed, wraps

Behaviour:
- Reset (async assert, sync release): every output is 0. Internal state is also 0: div_cnt, bit_cnt, shift registers, latched enable mask. Assertion mid-frame aborts the frame immediately, with no partial-sample valid. After release the frame restarts from bit_cnt=0.
- Clock generation:
  - div_cnt counts 0..BCLK_DIV-1.
  - At div_cnt==BCLK_DIV-1, bclk_out toggles and div_cnt returns to 0.
  - rise_stb: internal strobe in the cycle bclk_out goes 0->1. fall_stb: the same for 1->0.
  - bit_cnt (0..2*SLOT_BITS-1) increments on fall_stb and wraps to 0.
  - lrcl_out is registered, = (bit_cnt >= SLOT_BITS), so it changes only with the BCLK falling edge.
- Capture (left slot only; mic SEL is grounded):
  - On rise_stb with 1 <= bit_cnt <= DATA_BITS, each lane shifts mic_data_in[i] in MSB-first.
  - bit_cnt==0 is the I2S one-bit delay and is ignored. Right-slot bits are ignored.
- Enable latch: mic_en_in is latched on rise_stb with bit_cnt==0. A mid-frame change takes effect in the next frame.
- Output:
  - Trigger: the cycle after rise_stb with bit_cnt==DATA_BITS.
  - Each enabled lane loads shift[DATA_BITS-1 -: SAMPLE_WIDTH]. This is truncation, no rounding.
  - Disabled lanes load 0.
  - data_valid_out is high for exactly that one cycle. frame_cnt_out increments in the same cycle and wraps 0xFFFF->0.
- Timing at defaults:
  - First valid at clk_in cycle BCLK_DIV + 2*BCLK_DIV*DATA_BITS + 1 = 593 after reset release (cycle 1 = first rising edge after release).
  - Valid period thereafter = 4*BCLK_DIV*SLOT_BITS = 2048 cycles.
- Clip:
  - On output update, an enabled lane whose loaded sample is max-positive (0111..1) or max-negative (1000..0) sets clip_out[i].
  - clip_clr_in clears all flags.
  - Clear and set in the same cycle: set wins.
- audio_out holds between strobes. Sign is two's complement, as driven by the mic.

Decomposition:
- Package i2s_pkg holds:
  - the default constants (BCLK_DIV_DEFAULT, SLOT_BITS_DEFAULT, DATA_BITS_DEFAULT);
  - a function returning the max-positive and max-negative SAMPLE_WIDTH values used for clip detection.
- One sub-module, i2s_clk_gen: div_cnt, bit_cnt, bclk_out, lrcl_out, rise_stb, fall_stb, parameterised by BCLK_DIV and SLOT_BITS.
- Capture lanes are a generate loop in the top module.

Test Plan:
- Defaults; BFM mics drive 18'h2AAAA, 18'h15555 and 18'h00004 on lanes 0..2. Expect:
  - audio_out lanes = 16'hAAAA, 16'h5555, 16'h0001;
  - first data_valid_out at cycle 593;
  - subsequent strobes exactly 2048 apart;
  - frame_cnt_out = 1, 2, 3.
- Clock check: bclk_out period 32 cycles, 50% duty; lrcl_out period 2048 cycles with 1024 high; lrcl_out edges coincide with bclk_out falling edges.
- Lane 1 drives 18'h1FFFF and lane 2 drives 18'h20000. Expect:
  - samples 16'h7FFF and 16'h8000;
  - clip_out = 3'b110 and sticky across frames;
  - clip_clr_in pulse while clipping continues -> flags remain set after the next strobe;
  - stop clipping, then pulse clip_clr_in -> clip_out = 0.
- mic_en_in 3'b111->3'b101 at bit_cnt 10 of frame N. Expect:
  - frame N lane 1 still valid data;
  - frame N+1 lane 1 = 0, other lanes unchanged.
- Assert rst_in at bit_cnt 12 for 3 cycles. Expect:
  - all outputs 0 immediately;
  - no strobe for the aborted frame;
  - first strobe 593 cycles after release.
- NUM_MICS=4, BCLK_DIV=8, SAMPLE_WIDTH=18; lanes drive 18'h00001..18'h00004. Expect exact 18-bit values per lane and valid period 1024 cycles.
